// File: rtl/registrador_piso_pkg.sv
// Shared definitions for the parallel register path (transmitter and receiver).
package registrador_piso_pkg;

    localparam int unsigned REG_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/registrador_piso_contador_bits.sv
// contador_bits: up-counter with async clear, sync clear and count enable.
module contador_bits #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         sclr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (sclr) begin
            q <= '0;
        end else if (en) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/registrador_piso.sv
// Parallel-in/serial-out transmit register with load handshake and done pulse.
// Optional even parity bit after the data bits when PARITY_EN is defined.
module registrador_piso
    import registrador_piso_pkg::*;
#(
    parameter int unsigned N         = REG_N,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] d,
    input  logic         load,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

`ifdef PARITY_EN
    localparam int unsigned F = N + 1;
`else
    localparam int unsigned F = N;
`endif
    localparam int unsigned CW = $clog2(N + 2);

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    sreg;
    logic [CW-1:0]   cnt;
    logic            capture;
    logic            last_bit;
`ifdef PARITY_EN
    logic            par;
`endif

    function automatic logic head_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] advance(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    contador_bits #(.W(CW)) u_cnt (
        .clk  (clk),
        .clr  (clr),
        .sclr (capture),
        .en   (state == ST_SHIFT),
        .q    (cnt)
    );

    // Next-state decode; the counter holds the index of the bit currently on sout.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        last_bit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    capture  = 1'b1;
                    state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(F - 1)) begin
                    last_bit = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // The head bit is registered straight into sout, so sreg keeps only the remaining bits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            ready      <= 1'b1;
`ifdef PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (capture) begin
                sreg       <= advance(d);
                sout       <= head_bit(d);
                sout_valid <= 1'b1;
                ready      <= 1'b0;
`ifdef PARITY_EN
                par        <= ^d;
`endif
            end else if (last_bit) begin
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                done       <= 1'b1;
            end else if (state == ST_SHIFT) begin
`ifdef PARITY_EN
                sout <= (cnt == CW'(N - 1)) ? par : head_bit(sreg);
`else
                sout <= head_bit(sreg);
`endif
                sreg <= advance(sreg);
            end else if (state == ST_DONE) begin
                ready <= 1'b1;
            end
        end
    end

endmodule
